b10_serial_counter: RTL and testbench

B10_SERIAL_COUNTER -- requirements
Module: b10_serial_counter

---
 rtl/b10_serial_counter.sv | 115 +++++++++++
 tb/tb_b10_serial_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/b10_serial_counter.sv
// Serial BCD incrementer: a single base-10 half adder is time-shared across the digits, LSB first, one digit per clock.
// Define B10_SERIAL_SAT_EN to saturate at all 9s instead of wrapping to all 0s.
module b10_serial_counter #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic           soc,
    output logic           eoc,
    output logic [4*N-1:0] count,
    output logic           ovf
);
    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic [4*N-1:0] count_q, count_d;

    logic [3:0]     digit_in, digit_sum;
    logic           digit_cout;
    logic           sat_hit;

    // The one shared half adder; a carry into 9 rolls over, and the >= keeps the output legal BCD.
    always_comb begin
        digit_in = count_q[4*idx_q +: 4];
        if (carry_q && (digit_in >= 4'd9)) begin
            digit_sum  = 4'd0;
            digit_cout = 1'b1;
        end else begin
            digit_sum  = digit_in + {3'b000, carry_q};
            digit_cout = 1'b0;
        end
    end

`ifdef B10_SERIAL_SAT_EN
    logic all_nines;
    always_comb begin
        all_nines = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (count_q[4*k +: 4] != 4'd9) all_nines = 1'b0;
        end
    end
    assign sat_hit = all_nines;
`else
    assign sat_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (soc) begin
                    if (sat_hit) begin
                        state_d = WAIT;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        idx_d   = '0;
                        carry_d = 1'b1;
                        ovf_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                count_d[4*idx_q +: 4] = digit_sum;
                carry_d               = digit_cout;
                if (!digit_cout) begin
                    state_d = WAIT;
                end else if (idx_q == LAST) begin
                    state_d = WAIT;
                    ovf_d   = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            WAIT: begin
                if (!soc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            // NOTE: the digit register is reset too; a partial increment must be discarded, not resumed.
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign eoc   = (state_q != RUN);
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_b10_serial_counter.sv
// Directed self-checking bench for b10_serial_counter (N=4), with hand-computed BCD results.
// Expectations for the wrap/saturate case follow B10_SERIAL_SAT_EN.
module tb_b10_serial_counter;
    localparam int N = 4;

    logic           clock;
    logic           reset_;
    logic           soc;
    logic           eoc;
    logic [4*N-1:0] count;
    logic           ovf;

    int n_cmp = 0;
    int n_err = 0;

    b10_serial_counter #(.N(N)) dut (
        .clock (clock),
        .reset_(reset_),
        .soc   (soc),
        .eoc   (eoc),
        .count (count),
        .ovf   (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One increment from IDLE; edges counts the sampling edge plus every edge until eoc is back high.
    task automatic do_inc(output int edges);
        soc = 1'b1;
        tick();
        soc   = 1'b0;
        edges = 1;
        while (eoc == 1'b0 && edges < 20) begin
            tick();
            edges++;
        end
        if (eoc !== 1'b1) check("inc_timeout", {31'd0, eoc}, 32'd1);
        tick();
    endtask

    task automatic inc_many(input int n);
        int e;
        for (int i = 0; i < n; i++) do_inc(e);
    endtask

    initial begin
        int e;
        reset_ = 1'b0;
        soc    = 1'b0;
        tick();
        tick();
        check("rst_count", {16'd0, count}, 32'h0000);
        check("rst_ovf",   {31'd0, ovf},   32'd0);
        check("rst_eoc",   {31'd0, eoc},   32'd1);
        reset_ = 1'b1;
        tick();

        // single-digit increment
        do_inc(e);
        check("inc1_edges", e, 32'd2);
        check("inc1_count", {16'd0, count}, 32'h0001);
        check("inc1_ovf",   {31'd0, ovf},   32'd0);

        // 0099 -> 0100 touches three digits
        inc_many(98);
        check("pre99_count", {16'd0, count}, 32'h0099);
        do_inc(e);
        check("inc99_edges", e, 32'd4);
        check("inc99_count", {16'd0, count}, 32'h0100);
        check("inc99_ovf",   {31'd0, ovf},   32'd0);

        // reset in the middle of 0999 -> 1000
        inc_many(899);
        check("pre999_count", {16'd0, count}, 32'h0999);
        soc = 1'b1;
        tick();
        soc = 1'b0;
        check("run_eoc", {31'd0, eoc}, 32'd0);
        tick();
        check("run1_count", {16'd0, count}, 32'h0990);
        check("run1_eoc",   {31'd0, eoc},   32'd0);
        reset_ = 1'b0;
        tick();
        check("midrst_count", {16'd0, count}, 32'h0000);
        check("midrst_ovf",   {31'd0, ovf},   32'd0);
        check("midrst_eoc",   {31'd0, eoc},   32'd1);
        reset_ = 1'b1;
        tick();
        check("postrst_eoc", {31'd0, eoc}, 32'd1);
        do_inc(e);
        check("postrst_count", {16'd0, count}, 32'h0001);

        // reset beats soc on the same edge
        reset_ = 1'b0;
        soc    = 1'b1;
        tick();
        check("prio_count", {16'd0, count}, 32'h0000);
        check("prio_eoc",   {31'd0, eoc},   32'd1);
        reset_ = 1'b1;
        soc    = 1'b0;
        tick();

        // held soc gives exactly one increment
        soc = 1'b1;
        repeat (20) tick();
        check("hold_count", {16'd0, count}, 32'h0001);
        check("hold_eoc",   {31'd0, eoc},   32'd1);
        soc = 1'b0;
        tick();
        check("hold_rel_count", {16'd0, count}, 32'h0001);
        do_inc(e);
        check("after_hold_edges", e, 32'd2);
        check("after_hold_count", {16'd0, count}, 32'h0002);

        // all nines
        inc_many(9997);
        check("pre9999_count", {16'd0, count}, 32'h9999);
        check("pre9999_ovf",   {31'd0, ovf},   32'd0);
        do_inc(e);
`ifdef B10_SERIAL_SAT_EN
        check("sat_edges", e, 32'd1);
        check("sat_count", {16'd0, count}, 32'h9999);
        check("sat_ovf",   {31'd0, ovf},   32'd1);
        repeat (3) tick();
        check("sat_ovf_hold", {31'd0, ovf}, 32'd1);
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        tick();
        do_inc(e);
        check("sat_next_count", {16'd0, count}, 32'h0001);
        check("sat_next_ovf",   {31'd0, ovf},   32'd0);
`else
        check("wrap_edges", e, 32'd5);
        check("wrap_count", {16'd0, count}, 32'h0000);
        check("wrap_ovf",   {31'd0, ovf},   32'd1);
        repeat (3) tick();
        check("wrap_ovf_hold", {31'd0, ovf}, 32'd1);
        do_inc(e);
        check("wrap_next_count", {16'd0, count}, 32'h0001);
        check("wrap_next_ovf",   {31'd0, ovf},   32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
